instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Packs instruction fields into 32-bit code words and streams them into instruction memory.
//  It is the inverse of the decode stage and uses the same format:
//   - opcode = code[31:26]
//   - 0x00 LDI   : Rdst2[25:21], imm[15:0]
//   - 0x01 MOV   : Rdst2[25:21], Rsrc2[4:0]
//   - 0x02 LOAD  : Rdst2[25:21], RsrcAdd[7:0]
//   - 0x03 STORE : RdstAdd[25:18], Rsrc2[4:0]
//   - 0x04..0x10 ALU : Rdst2[25:21], Rdst1[20:16], Rsrc2[9:5], Rsrc1[4:0]
//  Sits between the test/boot program source and the Harvard instruction memory write port.
// PARAMETERS
//  ADDR_W   8      instruction memory address width
//  DEPTH    256    words available for the program (1..2**ADDR_W)
//  LAST_OP  6'h10  highest legal opcode; any opcode above it is illegal
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       synchronous, active-high reset
//  start       in   1       pulse: begin a new program load at address 0
//  in_valid    in   1       field bundle valid
//  in_ready    out  1       encoder accepts a bundle (comb: state==LOAD && !start)
//  in_op       in   6       opcode
//  in_rd2      in   5       Rdst2
//  in_rd1      in   5       Rdst1
//  in_rs2      in   5       Rsrc2
//  in_rs1      in   5       Rsrc1
//  in_adr      in   8       RsrcAdd (LOAD) / RdstAdd (STORE)
//  in_imm      in   16      immediate (LDI)
//  in_last     in   1       final instruction of the program
//  imem_we     out  1       instruction memory write strobe (registered)
//  imem_addr   out  ADDR_W  write address (registered)
//  imem_wdata  out  32      encoded word (registered)
//  count       out  ADDR_W+1  words written since start
//  done        out  1       high in DONE
//  full        out  1       sticky: DEPTH words written
//  err         out  1       high in ERR
//  err_op      out  6       opcode that caused ERR
// BEHAVIOUR
//  Reset: state=IDLE; imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, full=0, err=0, err_op=0.
//  States: IDLE, LOAD, DONE, FULL, ERR.
//   - start in any state -> LOAD: addr=0, count=0, full/err/err_op cleared.
//   - No bundle is accepted in the start cycle.
//  Accept: in_valid && in_ready at edge N.
//   - Legal opcode: imem_we=1, imem_addr=count[ADDR_W-1:0], imem_wdata=encoding during cycle N+1.
//   - count increments at edge N.
//   - imem_we is a single-cycle strobe; it is 0 in every cycle with no accept at the previous edge.
//  Encoding:
//   - Every bit not listed for the opcode is 0.
//   - Fields are truncated to the slice widths above. in_adr is shifted as a full 8-bit field.
//   - Unused input fields are ignored.
//  Back-to-back accepts give one write per cycle at consecutive addresses; there is no bubble.
//  Transitions out of LOAD, evaluated in priority order on an accepted bundle:
//   - Illegal opcode (>LAST_OP): no write; -> ERR; err_op=in_op; count unchanged.
//   - in_last: -> DONE. If this word also makes count==DEPTH, full=1 as well.
//   - count becomes DEPTH: -> FULL; full=1. in_ready stays 0 until start.
//  DONE, FULL, ERR: in_ready=0; held until start or rst.
//  IDLE: in_ready=0; in_valid is ignored.
//  Reset mid-load:
//   - All state clears at the first edge with rst=1.
//   - A write strobe already on imem_we during that cycle is completed by memory at that edge; no further writes follow.
//  start and rst in the same cycle: rst wins -> IDLE.
// TESTING
//  1. rst, start, LDI rd2=3 imm=16'hBEEF last=1 -> cycle+1: we=1 addr=0 wdata=32'h0060BEEF; then done=1, count=1.
//  2. Stream op=04 rd2=1 rd1=2 rs2=3 rs1=4 / STORE adr=8'hA5 rs2=7 / LOAD rd2=31 adr=8'h10 (last), back-to-back ->
//     wdata 32'h10220064, 32'h0E940007, 32'h0BE00010 at addr 0,1,2 on consecutive cycles; done=1.
//  3. Illegal op=6'h11 after 2 legal words -> no write for it; err=1, err_op=6'h11, count=2, in_ready=0;
//     start -> err=0, count=0.
//  4. DEPTH=4, 5 non-last words offered -> 4 writes at addr 0..3; full=1; 5th never accepted (in_ready=0).
//  5. rst asserted mid-stream after 2 accepts -> next cycle imem_we=0, count=0, state IDLE, in_ready=0.
//  6. start with in_valid=1 in the same cycle -> not accepted; bundle accepted next cycle at addr 0.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder: packs decoded instruction fields into 32-bit code words
// and streams them, one per cycle, into the instruction memory write port.
module instr_encoder #(
    parameter int         ADDR_W  = 8,
    parameter int         DEPTH   = 256,
    parameter logic [5:0] LAST_OP = 6'h10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd2,
    input  logic [4:0]        in_rd1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rs1,
    input  logic [7:0]        in_adr,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [5:0]        err_op
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_FULL,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W:0]     r_count;
    logic                r_full;
    logic [5:0]          r_err_op;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;

    logic                w_accept;
    logic                w_legal;
    logic [ADDR_W:0]     w_count_inc;
    logic [31:0]         w_word;

    assign w_accept    = in_valid && in_ready;
    assign w_legal     = (in_op <= LAST_OP);
    assign w_count_inc = r_count + 1'b1;

    // Field packing; every bit outside the opcode's slices stays zero.
    always_comb begin
        w_word = '0;
        case (in_op)
            6'h00:   w_word = {in_op, in_rd2, 5'b0, in_imm};
            6'h01:   w_word = {in_op, in_rd2, 16'b0, in_rs2};
            6'h02:   w_word = {in_op, in_rd2, 13'b0, in_adr};
            6'h03:   w_word = {in_op, in_adr, 13'b0, in_rs2};
            default: begin
                if (w_legal) begin
                    w_word = {in_op, in_rd2, in_rd1, 6'b0, in_rs2, in_rs1};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Illegal opcode outranks in_last, which outranks running out of space.
    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = S_LOAD;
        end else if (r_state == S_LOAD && w_accept) begin
            if (!w_legal) begin
                w_state_next = S_ERR;
            end else if (in_last) begin
                w_state_next = S_DONE;
            end else if (w_count_inc == DEPTH_C) begin
                w_state_next = S_FULL;
            end
        end
    end

    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (r_state)
            S_LOAD:  in_ready = !start;
            S_DONE:  done     = 1'b1;
            S_ERR:   err      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_full   <= 1'b0;
            r_err_op <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_we <= w_accept && w_legal;
            if (start) begin
                r_count  <= '0;
                r_full   <= 1'b0;
                r_err_op <= '0;
                r_addr   <= '0;
            end else if (w_accept) begin
                if (w_legal) begin
                    r_addr  <= r_count[ADDR_W-1:0];
                    r_wdata <= w_word;
                    r_count <= w_count_inc;
                    if (w_count_inc == DEPTH_C) begin
                        r_full <= 1'b1;
                    end
                end else begin
                    r_err_op <= in_op;
                end
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign full       = r_full;
    assign err_op     = r_err_op;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table vectors, hand sequences for the multi-cycle
// corners, and random streams checked against a transaction-level model.
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, in_valid, in_last;
    logic [5:0]  in_op;
    logic [4:0]  in_rd2, in_rd1, in_rs2, in_rs1;
    logic [7:0]  in_adr;
    logic [15:0] in_imm;

    logic        a_ready, a_we, a_done, a_full, a_err;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic [8:0]  a_count;
    logic [5:0]  a_err_op;

    logic        b_rst, b_start, b_valid;
    logic        b_ready, b_we, b_done, b_full, b_err;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_count;
    logic [5:0]  b_err_op;

    instr_encoder dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_ready),
        .in_op(in_op), .in_rd2(in_rd2), .in_rd1(in_rd1), .in_rs2(in_rs2), .in_rs1(in_rs1),
        .in_adr(in_adr), .in_imm(in_imm), .in_last(in_last),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata), .count(a_count),
        .done(a_done), .full(a_full), .err(a_err), .err_op(a_err_op)
    );

    instr_encoder #(.ADDR_W(2), .DEPTH(4)) dut4 (
        .clk(clk), .rst(b_rst), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
        .in_op(in_op), .in_rd2(in_rd2), .in_rd1(in_rd1), .in_rs2(in_rs2), .in_rs1(in_rs1),
        .in_adr(in_adr), .in_imm(in_imm), .in_last(in_last),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata), .count(b_count),
        .done(b_done), .full(b_full), .err(b_err), .err_op(b_err_op)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference encoding built from the field positions with shifts.
    function automatic logic [31:0] ref_encode(input logic [5:0] op, input logic [4:0] rd2,
            input logic [4:0] rd1, input logic [4:0] rs2, input logic [4:0] rs1,
            input logic [7:0] adr, input logic [15:0] imm);
        logic [31:0] w;
        w = 32'(op) << 26;
        if (op == 0)       w = w | (32'(rd2) << 21) | 32'(imm);
        else if (op == 1)  w = w | (32'(rd2) << 21) | 32'(rs2);
        else if (op == 2)  w = w | (32'(rd2) << 21) | 32'(adr);
        else if (op == 3)  w = w | (32'(adr) << 18) | 32'(rs2);
        else if (op <= 16) w = w | (32'(rd2) << 21) | (32'(rd1) << 16) | (32'(rs2) << 5) | 32'(rs1);
        else               w = 0;
        return w;
    endfunction

    // Model of the main instance (256-word memory)
    localparam int MDEPTH = 256;
    typedef enum {M_IDLE, M_LOAD, M_DONE, M_FULL, M_ERR} mstate_t;
    mstate_t     m_state;
    int          m_count;
    bit          m_full, m_we;
    int          m_err_op, m_addr;
    logic [31:0] m_data;

    task automatic cyc(input logic r, input logic s, input logic v, input logic [5:0] op,
            input logic [4:0] rd2, input logic [4:0] rd1, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [7:0] adr, input logic [15:0] imm,
            input logic last);
        bit exp_ready, acc;
        rst = r; start = s; in_valid = v; in_op = op; in_rd2 = rd2; in_rd1 = rd1;
        in_rs2 = rs2; in_rs1 = rs1; in_adr = adr; in_imm = imm; in_last = last;
        #1;
        exp_ready = (m_state == M_LOAD) && !s;
        chk("in_ready", 32'(a_ready), 32'(exp_ready));
        acc = v && exp_ready;
        m_we = 0;
        if (r) begin
            m_state = M_IDLE; m_count = 0; m_full = 0; m_err_op = 0;
        end else if (s) begin
            m_state = M_LOAD; m_count = 0; m_full = 0; m_err_op = 0;
        end else if (acc) begin
            if (op > 16) begin
                m_state = M_ERR; m_err_op = op;
            end else begin
                m_we = 1; m_addr = m_count % MDEPTH;
                m_data = ref_encode(op, rd2, rd1, rs2, rs1, adr, imm);
                m_count++;
                if (m_count == MDEPTH) m_full = 1;
                if (last) m_state = M_DONE;
                else if (m_count == MDEPTH) m_state = M_FULL;
                $display("txn addr=%0d word=%h op=%h last=%0d", m_addr, m_data, op, last);
            end
        end
        @(posedge clk); #1;
        chk("imem_we", 32'(a_we), 32'(m_we));
        if (m_we) begin
            chk("imem_addr", 32'(a_addr), 32'(m_addr));
            chk("imem_wdata", a_wdata, m_data);
        end
        chk("count", 32'(a_count), 32'(m_count));
        chk("done", 32'(a_done), 32'(m_state == M_DONE));
        chk("full", 32'(a_full), 32'(m_full));
        chk("err", 32'(a_err), 32'(m_state == M_ERR));
        chk("err_op", 32'(a_err_op), 32'(m_err_op));
    endtask

    task automatic ctl(input logic r, input logic s);
        cyc(r, s, 1'b0, 6'h0, 5'h0, 5'h0, 5'h0, 5'h0, 8'h0, 16'h0, 1'b0);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd2, rd1, rs2, rs1;
        logic [7:0]  adr;
        logic [15:0] imm;
        logic [31:0] word;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{6'h00, 5'd3,  5'd0,  5'd0,  5'd0,  8'h00, 16'hBEEF, 32'h0060BEEF};
        tbl[1] = '{6'h04, 5'd1,  5'd2,  5'd3,  5'd4,  8'h00, 16'h0000, 32'h10220064};
        tbl[2] = '{6'h03, 5'd0,  5'd0,  5'd7,  5'd0,  8'hA5, 16'h0000, 32'h0E940007};
        tbl[3] = '{6'h02, 5'd31, 5'd0,  5'd0,  5'd0,  8'h10, 16'h0000, 32'h0BE00010};
        tbl[4] = '{6'h10, 5'd31, 5'd31, 5'd31, 5'd31, 8'hFF, 16'hFFFF, 32'h43FF03FF};
        tbl[5] = '{6'h01, 5'd5,  5'd7,  5'd9,  5'd3,  8'hFF, 16'hFFFF, 32'h04A00009};
        tbl[6] = '{6'h00, 5'd0,  5'd31, 5'd31, 5'd31, 8'hFF, 16'h1234, 32'h00001234};
        tbl[7] = '{6'h02, 5'd0,  5'd31, 5'd31, 5'd31, 8'hFF, 16'hFFFF, 32'h080000FF};

        rst = 1; start = 0; in_valid = 0; in_last = 0; in_op = 0; in_rd2 = 0; in_rd1 = 0;
        in_rs2 = 0; in_rs1 = 0; in_adr = 0; in_imm = 0;
        b_rst = 1; b_start = 0; b_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        m_state = M_IDLE; m_count = 0; m_full = 0; m_err_op = 0; m_we = 0; m_addr = 0; m_data = 0;
        chk("rst_we", 32'(a_we), 32'h0);
        chk("rst_addr", 32'(a_addr), 32'h0);
        chk("rst_wdata", a_wdata, 32'h0);
        chk("rst_count", 32'(a_count), 32'h0);
        chk("rst_flags", {29'h0, a_done, a_full, a_err}, 32'h0);
        chk("rst_err_op", 32'(a_err_op), 32'h0);
        chk("rst_ready", 32'(a_ready), 32'h0);

        // IDLE ignores in_valid
        cyc(0, 0, 1, 6'h00, 5'd1, 5'd0, 5'd0, 5'd0, 8'h0, 16'h1111, 1'b1);

        // Table vectors: one single-word program each
        for (int i = 0; i < 8; i++) begin
            ctl(0, 1);
            cyc(0, 0, 1, tbl[i].op, tbl[i].rd2, tbl[i].rd1, tbl[i].rs2, tbl[i].rs1,
                tbl[i].adr, tbl[i].imm, 1'b1);
            chk("tbl_word", a_wdata, tbl[i].word);
            chk("tbl_addr", 32'(a_addr), 32'h0);
        end

        // Back-to-back three-word stream
        ctl(0, 1);
        cyc(0, 0, 1, 6'h04, 5'd1, 5'd2, 5'd3, 5'd4, 8'h00, 16'h0, 1'b0);
        chk("b2b_w0", a_wdata, 32'h10220064);
        cyc(0, 0, 1, 6'h03, 5'd0, 5'd0, 5'd7, 5'd0, 8'hA5, 16'h0, 1'b0);
        chk("b2b_w1", a_wdata, 32'h0E940007);
        cyc(0, 0, 1, 6'h02, 5'd31, 5'd0, 5'd0, 5'd0, 8'h10, 16'h0, 1'b1);
        chk("b2b_w2", a_wdata, 32'h0BE00010);
        chk("b2b_addr2", 32'(a_addr), 32'h2);
        ctl(0, 0);
        chk("b2b_done", 32'(a_done), 32'h1);

        // Illegal opcode after two legal words
        ctl(0, 1);
        cyc(0, 0, 1, 6'h05, 5'd1, 5'd1, 5'd1, 5'd1, 8'h0, 16'h0, 1'b0);
        cyc(0, 0, 1, 6'h06, 5'd2, 5'd2, 5'd2, 5'd2, 8'h0, 16'h0, 1'b0);
        cyc(0, 0, 1, 6'h11, 5'd3, 5'd3, 5'd3, 5'd3, 8'h0, 16'h0, 1'b1);
        chk("ill_err_op", 32'(a_err_op), 32'h11);
        chk("ill_count", 32'(a_count), 32'h2);
        ctl(0, 0);
        ctl(0, 1);
        chk("ill_clear", {31'h0, a_err}, 32'h0);

        // Reset mid-stream after two accepts
        cyc(0, 0, 1, 6'h07, 5'd1, 5'd2, 5'd3, 5'd4, 8'h0, 16'h0, 1'b0);
        cyc(0, 0, 1, 6'h08, 5'd1, 5'd2, 5'd3, 5'd4, 8'h0, 16'h0, 1'b0);
        cyc(1, 0, 1, 6'h09, 5'd1, 5'd2, 5'd3, 5'd4, 8'h0, 16'h0, 1'b0);
        chk("mid_rst_we", 32'(a_we), 32'h0);
        chk("mid_rst_count", 32'(a_count), 32'h0);
        ctl(0, 0);

        // start together with in_valid, then accepted next cycle at address 0
        cyc(0, 1, 1, 6'h00, 5'd9, 5'd0, 5'd0, 5'd0, 8'h0, 16'hCAFE, 1'b0);
        chk("start_v_we", 32'(a_we), 32'h0);
        cyc(0, 0, 1, 6'h00, 5'd9, 5'd0, 5'd0, 5'd0, 8'h0, 16'hCAFE, 1'b1);
        chk("start_v_word", a_wdata, 32'h0120CAFE);

        // start and rst together: rst wins
        cyc(1, 1, 0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 8'h0, 16'h0, 1'b0);

        // Full 256-word program whose last word also fills memory
        ctl(0, 1);
        for (int k = 0; k < MDEPTH; k++) begin
            cyc(0, 0, 1, 6'(k % 17), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                8'($urandom), 16'($urandom), 1'(k == MDEPTH - 1));
        end
        chk("last_full", 32'(a_full), 32'h1);
        chk("last_done", 32'(a_done), 32'h1);

        // Random traffic
        ctl(0, 1);
        for (int n = 0; n < 600; n++) begin
            cyc(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 14) == 0),
                1'($urandom_range(0, 3) != 0), 6'($urandom_range(0, 18)),
                5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                8'($urandom), 16'($urandom), 1'($urandom_range(0, 9) == 0));
        end
        ctl(1, 0);

        // 4-word instance: fifth word must be refused
        in_valid = 0;
        b_rst = 1; @(posedge clk); #1;
        b_rst = 0; b_start = 1; @(posedge clk); #1;
        b_start = 0;
        for (int k = 0; k < 5; k++) begin
            b_valid = 1; in_op = 6'h04; in_rd2 = 5'(k); in_rd1 = 5'(k + 1);
            in_rs2 = 5'(k + 2); in_rs1 = 5'(k + 3); in_last = 0;
            #1;
            chk("d4_ready", 32'(b_ready), 32'(k < 4));
            @(posedge clk); #1;
            if (k < 4) begin
                chk("d4_we", 32'(b_we), 32'h1);
                chk("d4_addr", 32'(b_addr), 32'(k));
                chk("d4_wdata", b_wdata,
                    ref_encode(6'h04, 5'(k), 5'(k + 1), 5'(k + 2), 5'(k + 3), 8'h0, 16'h0));
                $display("txn dut4 addr=%0d word=%h", b_addr, b_wdata);
            end else begin
                chk("d4_no_we", 32'(b_we), 32'h0);
            end
        end
        b_valid = 0;
        chk("d4_full", 32'(b_full), 32'h1);
        chk("d4_count", 32'(b_count), 32'h4);
        chk("d4_done", 32'(b_done), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
